// File: rtl/nabp_shifter_accumulator_pkg.sv
// Shared types and constants for the shifter accumulator and its LUT.
// Fixed-point base format matches the shifter LUT generator.
package nabp_shifter_accumulator_pkg;

  localparam int unsigned kAngleLength = 8;
  localparam int unsigned kBaseWidth   = 16;
  localparam int unsigned kFracBits    = 14;
  localparam int unsigned kNumLines    = 64;
  localparam int unsigned kLineWidth   = 6;
  localparam int unsigned kShiftWidth  = 8;
  localparam int unsigned kAccuWidth   = kBaseWidth + kLineWidth;
  localparam int unsigned kAxisLo      = 45;
  localparam int unsigned kAxisHi      = 135;

  typedef logic [kAngleLength-1:0]      angle_t;
  typedef logic signed [kBaseWidth-1:0] accu_base_t;
  typedef logic signed [kAccuWidth-1:0] accu_t;
  typedef logic [kLineWidth-1:0]        line_t;
  typedef logic signed [kShiftWidth-1:0] shift_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_LOAD   = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  typedef struct packed {
    shift_t shift;
    line_t  line;
    logic   axis;
    logic   last;
  } shift_beat_t;

  // Steep angles (45..134) shift along y, the rest along x.
  function automatic logic is_axis_y(angle_t a);
    return (a >= angle_t'(kAxisLo)) && (a < angle_t'(kAxisHi));
  endfunction

endpackage

// File: rtl/nabp_shifter_accumulator_if.sv
// Valid/ready stream carrying one rounded shift per projection line.
interface nabp_shifter_accumulator_if;
  import nabp_shifter_accumulator_pkg::*;

  shift_beat_t beat;
  logic        valid;
  logic        ready;

  modport master (output beat, output valid, input ready);
  modport slave  (input beat, input valid, output ready);

endinterface

// File: rtl/nabp_shifter_accumulator_round.sv
// Fixed-point accumulator to integer shift: round half toward +inf, then truncate.
module nabp_shifter_accumulator_round
  import nabp_shifter_accumulator_pkg::*;
(
  input  accu_t  accu_i,
  output shift_t shift_c_o
);

  localparam accu_t kHalf = accu_t'(2 ** (kFracBits - 1));

  accu_t biased;

  assign biased    = accu_i + kHalf;
  assign shift_c_o = shift_t'(biased >>> kFracBits);

endmodule

// File: rtl/nabp_shifter_accumulator.sv
// Looks up the per-line increment for an angle, then streams one rounded
// shift per line, accumulating the increment on every accepted beat.
module nabp_shifter_accumulator
  import nabp_shifter_accumulator_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  angle_t     angle_i,
  output logic       busy_o,
  output angle_t     sh_angle_o,
  input  accu_base_t sh_accu_base_i,
  nabp_shifter_accumulator_if.master shift_if
);

  state_e state_q, state_d;

  angle_t sh_angle_q, sh_angle_d;
  logic   axis_q, axis_d;
  logic   busy_q, busy_d;
  accu_t  base_q, base_d;
  accu_t  accu_q, accu_d;
  line_t  line_q, line_d;
  shift_t shift_q, shift_d;
  logic   valid_q, valid_d;
  logic   last_q, last_d;

  logic   hs;
  accu_t  accu_next;
  shift_t shift_next;

  assign hs        = valid_q & shift_if.ready;
  assign accu_next = accu_q + base_q;

  nabp_shifter_accumulator_round u_round (
    .accu_i    (accu_next),
    .shift_c_o (shift_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_RUN;
      ST_RUN:    if (hs && last_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; everything holds unless a transition acts.
  always_comb begin
    sh_angle_d = sh_angle_q;
    axis_d     = axis_q;
    busy_d     = busy_q;
    base_d     = base_q;
    accu_d     = accu_q;
    line_d     = line_q;
    shift_d    = shift_q;
    valid_d    = valid_q;
    last_d     = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sh_angle_d = angle_i;
          axis_d     = is_axis_y(angle_i);
          busy_d     = 1'b1;
        end
      end
      ST_LOOKUP: begin
      end
      ST_LOAD: begin
        base_d  = accu_t'(sh_accu_base_i);
        accu_d  = '0;
        line_d  = '0;
        shift_d = '0;
        valid_d = 1'b1;
        last_d  = (kNumLines == 1);
      end
      ST_RUN: begin
        if (hs) begin
          if (last_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            accu_d  = accu_next;
            line_d  = line_q + line_t'(1);
            shift_d = shift_next;
            last_d  = (line_q + line_t'(1)) == line_t'(kNumLines - 1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_angle_q <= '0;
      axis_q     <= 1'b0;
      busy_q     <= 1'b0;
      base_q     <= '0;
      accu_q     <= '0;
      line_q     <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      sh_angle_q <= sh_angle_d;
      axis_q     <= axis_d;
      busy_q     <= busy_d;
      base_q     <= base_d;
      accu_q     <= accu_d;
      line_q     <= line_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign busy_o          = busy_q;
  assign sh_angle_o      = sh_angle_q;
  assign shift_if.valid  = valid_q;
  assign shift_if.beat   = '{shift: shift_q, line: line_q, axis: axis_q, last: last_q};

endmodule

// File: tb/tb_nabp_shifter_accumulator.sv
// Randomised bench for the shifter accumulator against a per-angle shift model.
module tb_nabp_shifter_accumulator;
  import nabp_shifter_accumulator_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  angle_t     angle = '0;
  logic       busy;
  angle_t     sh_angle;
  accu_base_t sh_accu_base = '0;

  nabp_shifter_accumulator_if bus ();

  nabp_shifter_accumulator dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start),
    .angle_i        (angle),
    .busy_o         (busy),
    .sh_angle_o     (sh_angle),
    .sh_accu_base_i (sh_accu_base),
    .shift_if       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int shift;
    int line;
    bit axis;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   beats = 0;
  int   rec_shift[64];

  task automatic chk(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Bench-side LUT: fixed values for the directed angles, a bounded hash elsewhere.
  function automatic int lut_val(int a);
    case (a)
      0:       return 0;
      45:      return 16384;
      90:      return 0;
      135:     return -16384;
      30:      return 'h24F3;
      default: return ((a * 2971) % 32769) - 16384;
    endcase
  endfunction

  always @(posedge clk) sh_accu_base <= accu_base_t'(lut_val(int'(sh_angle)));

  // Line k shift = floor((k*base + 0.5) in integer units), kept to 8 signed bits.
  function automatic int model_shift(int base, int k);
    longint v;
    byte    b;
    v = longint'(k) * longint'(base) + 64'sd8192;
    v = v >>> 14;
    b = byte'(v);
    return int'(b);
  endfunction

  task automatic push_run(int a);
    int base;
    base = lut_val(a);
    for (int k = 0; k < 64; k++)
      exp_q.push_back('{model_shift(base, k), k, (a >= 45 && a < 135), (k == 63)});
  endtask

  // Consumer ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  int ready_mode = 0;
  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (ready_mode)
      1:       bus.ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
      2:       bus.ready = 1'($urandom_range(0, 1));
      default: bus.ready = 1'b1;
    endcase
  end

  // Stream checker: held beats stay stable, accepted beats match the model in order.
  shift_beat_t prev_beat;
  bit          prev_hold = 1'b0;
  bit          expect_idle = 1'b0;
  exp_t        e;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold   = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("idle_valid", int'(bus.valid), 0);
        chk("idle_busy", int'(busy), 0);
        expect_idle = 1'b0;
      end
      if (prev_hold) begin
        chk("hold_valid", int'(bus.valid), 1);
        chk("hold_beat", int'(bus.beat), int'(prev_beat));
      end
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got line %0d, expected no beat (t=%0t)", bus.beat.line, $time);
        end else begin
          e = exp_q.pop_front();
          chk("shift", int'(bus.beat.shift), e.shift);
          chk("line", int'(bus.beat.line), e.line);
          chk("axis", int'(bus.beat.axis), int'(e.axis));
          chk("last", int'(bus.beat.last), int'(e.last));
          rec_shift[bus.beat.line] = int'(bus.beat.shift);
          beats++;
          if (bus.beat.last) expect_idle = 1'b1;
        end
      end
      prev_hold = bus.valid && !bus.ready;
      prev_beat = bus.beat;
    end
  end

  task automatic do_start(int a);
    @(posedge clk); #2;
    start = 1'b1;
    angle = angle_t'(a);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("done_timeout_busy", int'(busy), 0);
    chk("beat_count", beats, 64);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_angle(int a, int mode, bit chk_lat);
    ready_mode = mode;
    beats = 0;
    push_run(a);
    do_start(a);
    chk("busy_after_start", int'(busy), 1);
    chk("sh_angle", int'(sh_angle), a);
    if (chk_lat) begin
      chk("lat_valid_p0", int'(bus.valid), 0);
      @(posedge clk); #2;
      chk("lat_valid_p1", int'(bus.valid), 0);
      @(posedge clk); #2;
      chk("lat_valid_p2", int'(bus.valid), 1);
    end
    wait_done();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_sh_angle", int'(sh_angle), 0);
    chk("rst_shift", int'(bus.beat.shift), 0);
    chk("rst_line", int'(bus.beat.line), 0);
    chk("rst_last", int'(bus.beat.last), 0);
    chk("rst_axis", int'(bus.beat.axis), 0);
    reset_n = 1'b1;

    run_angle(0, 0, 1'b1);
    run_angle(45, 0, 1'b1);
    chk("a45_line1", rec_shift[1], 1);
    chk("a45_line63", rec_shift[63], 63);
    run_angle(135, 0, 1'b1);
    chk("a135_line1", rec_shift[1], -1);
    chk("a135_line63", rec_shift[63], -63);
    run_angle(90, 0, 1'b0);
    run_angle(30, 1, 1'b1);
    chk("a30_line0", rec_shift[0], 0);
    chk("a30_line1", rec_shift[1], 1);
    chk("a30_line2", rec_shift[2], 1);
    chk("a30_line3", rec_shift[3], 2);

    for (int i = 0; i < 20; i++)
      run_angle(int'($urandom_range(0, 179)), int'($urandom_range(0, 2)), (i < 3));

    // start pulses in LOOKUP and RUN must be ignored
    ready_mode = 2;
    beats = 0;
    push_run(30);
    @(posedge clk); #2;
    start = 1'b1;
    angle = angle_t'(30);
    @(posedge clk); #2;
    angle = angle_t'(100);
    @(posedge clk); #2;
    start = 1'b0;
    chk("ign_lookup_sh_angle", int'(sh_angle), 30);
    repeat (10) @(posedge clk);
    #2;
    start = 1'b1;
    angle = angle_t'(60);
    @(posedge clk); #2;
    start = 1'b0;
    chk("ign_run_sh_angle", int'(sh_angle), 30);
    wait_done();
    chk("ign_final_sh_angle", int'(sh_angle), 30);

    // reset while line 10 is presented aborts the run
    ready_mode = 0;
    beats = 0;
    push_run(45);
    do_start(45);
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      @(posedge clk); #2;
      if (bus.valid && bus.beat.line == line_t'(10)) found = 1;
    end
    chk("abort_reached_line10", found, 1);
    reset_n = 1'b0;
    @(posedge clk); #2;
    chk("abort_valid", int'(bus.valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_line", int'(bus.beat.line), 0);
    chk("abort_beats", beats, 10);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(posedge clk); #2;
      chk("abort_no_beat", int'(bus.valid), 0);
    end
    run_angle(45, 0, 1'b1);
    chk("post_abort_line0", rec_shift[0], 0);
    chk("post_abort_line63", rec_shift[63], 63);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
